noc_merge_sel: RTL

// Clocked merge that sits at the consumer end of the 2-input arbiter's 1-bit decision channel.
// Per packet:
//  - receive one grant value (sel) from the arbiter;
//  - receive one WIDTH-bit packet from requester input sel;
//  - forward the packet on a single output channel.
// All channels are 4-phase bundled-data: req up, ack up, req down, ack down.

---
 rtl/noc_merge_sel.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/noc_merge_sel.sv
// Consumer-side merge for a 2-input arbiter: takes a 1-bit grant, handshakes the granted
// requester, and forwards its packet on one 4-phase bundled-data output channel.
module noc_merge_sel #(
   parameter int WIDTH       = 33,
   parameter int SYNC_STAGES = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sel_req,
   input  logic             sel_data,
   output logic             sel_ack,
   input  logic             in0_req,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ack,
   input  logic             in1_req,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ack,
   output logic             out_req,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ack,
   output logic [CNT_W-1:0] pkt_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL_RTZ,
      S_IN_WAIT,
      S_IN_RTZ,
      S_OUT_ACK,
      S_OUT_RTZ
   } state_t;

   logic [3:0] hs_raw;
   logic [3:0] hs_smp;
   logic       sel_req_s;
   logic       in0_req_s;
   logic       in1_req_s;
   logic       out_ack_s;

   assign hs_raw = {out_ack, in1_req, in0_req, sel_req};

   // Handshake inputs only; data is bundled and stable while its req is seen high.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign hs_smp = hs_raw;
      end else begin : g_sync
         logic [3:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
            end else begin
               sync_q[0] <= hs_raw;
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign hs_smp = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign sel_req_s = hs_smp[0];
   assign in0_req_s = hs_smp[1];
   assign in1_req_s = hs_smp[2];
   assign out_ack_s = hs_smp[3];

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic             sel_ack_q, sel_ack_d;
   logic             in0_ack_q, in0_ack_d;
   logic             in1_ack_q, in1_ack_d;
   logic             out_req_q, out_req_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_g;
   logic [WIDTH-1:0] data_g;

   assign req_g  = sel_q ? in1_req_s : in0_req_s;
   assign data_g = sel_q ? in1_data  : in0_data;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      sel_ack_d  = sel_ack_q;
      in0_ack_d  = in0_ack_q;
      in1_ack_d  = in1_ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (sel_req_s) begin
               sel_d     = sel_data;
               sel_ack_d = 1'b1;
               state_d   = S_SEL_RTZ;
            end
         end
         S_SEL_RTZ: begin
            if (!sel_req_s) begin
               sel_ack_d = 1'b0;
               state_d   = S_IN_WAIT;
            end
         end
         S_IN_WAIT: begin
            if (req_g) begin
               out_data_d = data_g;
               if (sel_q) in1_ack_d = 1'b1;
               else       in0_ack_d = 1'b1;
               state_d = S_IN_RTZ;
            end
         end
         S_IN_RTZ: begin
            // A stale out_ack from the consumer must not start a new output cycle.
            if (!req_g && !out_ack_s) begin
               in0_ack_d = 1'b0;
               in1_ack_d = 1'b0;
               out_req_d = 1'b1;
               state_d   = S_OUT_ACK;
            end
         end
         S_OUT_ACK: begin
            if (out_ack_s) begin
               out_req_d = 1'b0;
               state_d   = S_OUT_RTZ;
            end
         end
         S_OUT_RTZ: begin
            if (!out_ack_s) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= 1'b0;
         sel_ack_q  <= 1'b0;
         in0_ack_q  <= 1'b0;
         in1_ack_q  <= 1'b0;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         sel_ack_q  <= sel_ack_d;
         in0_ack_q  <= in0_ack_d;
         in1_ack_q  <= in1_ack_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
         cnt_q      <= cnt_d;
      end
   end

   assign sel_ack  = sel_ack_q;
   assign in0_ack  = in0_ack_q;
   assign in1_ack  = in1_ack_q;
   assign out_req  = out_req_q;
   assign out_data = out_data_q;
   assign pkt_cnt  = cnt_q;

endmodule
